// File: rtl/riscv_pkg.sv
// Shared core types: MEM-stage data bus controller state and default watchdog limit.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } dmem_state_t;

  localparam int DMEM_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus responder: one outstanding valid/ready transaction per held request,
// with a watchdog that converts an unresponsive bus into an access error.
module dmem_bus_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dmem_periph_req,
  input  logic                dmem_we_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_wstrb_i,
  output logic                mem_done_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_err_o,
  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic                bus_req_we_o,
  output logic [ADDR_W-1:0]   bus_req_addr_o,
  output logic [DATA_W-1:0]   bus_req_wdata_o,
  output logic [DATA_W/8-1:0] bus_req_wstrb_o,
  input  logic                bus_rsp_valid_i,
  input  logic [DATA_W-1:0]   bus_rsp_rdata_i,
  input  logic                bus_rsp_err_i,
  output dmem_state_t         dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_SAT  = '1;

  dmem_state_t     state;
  logic [WD_W-1:0] wd_cnt;
  logic            withdrawn;
  logic            timed_out;
  logic            req_live;

  // Handshake: a request transfers on the cycle bus_req_valid_o && bus_req_ready_i; valid and
  // its payload stay stable until then. Responses have no ready and count only while in WAIT.
  assign timed_out = (TIMEOUT_CYCLES > 0) && (wd_cnt >= WD_LAST);
  assign req_live  = dmem_periph_req && !withdrawn;
  assign dbg_state = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      withdrawn       <= 1'b0;
      mem_done_o      <= 1'b0;
      mem_err_o       <= 1'b0;
      mem_rdata_o     <= '0;
      bus_req_valid_o <= 1'b0;
      bus_req_we_o    <= 1'b0;
      bus_req_addr_o  <= '0;
      bus_req_wdata_o <= '0;
      bus_req_wstrb_o <= '0;
    end else begin
      mem_done_o <= 1'b0;
      if (state == REQ || state == WAIT) begin
        if (wd_cnt != WD_SAT) wd_cnt <= wd_cnt + WD_W'(1);
        if (!dmem_periph_req) withdrawn <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (dmem_periph_req) begin
            bus_req_we_o    <= dmem_we_i;
            bus_req_addr_o  <= dmem_addr_i;
            bus_req_wdata_o <= dmem_wdata_i;
            bus_req_wstrb_o <= dmem_we_i ? dmem_wstrb_i : '0;
            bus_req_valid_o <= 1'b1;
            wd_cnt          <= '0;
            withdrawn       <= 1'b0;
            state           <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready_i) begin
            bus_req_valid_o <= 1'b0;
            state           <= WAIT;
          end else if (timed_out) begin
            bus_req_valid_o <= 1'b0;
            mem_rdata_o     <= '0;
            mem_err_o       <= 1'b1;
            mem_done_o      <= req_live;
            state           <= DONE;
          end
        end
        WAIT: begin
          if (bus_rsp_valid_i) begin
            mem_rdata_o <= bus_rsp_rdata_i;
            mem_err_o   <= bus_rsp_err_i;
            mem_done_o  <= req_live;
            state       <= DONE;
          end else if (timed_out) begin
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b1;
            mem_done_o  <= req_live;
            state       <= DONE;
          end
        end
        DONE: begin
          // The request still high here belongs to the instruction just completed.
          mem_err_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Bench for dmem_bus_ctrl: directed scenarios plus randomized traffic, checked by done and bus monitors.
module tb_dmem_bus_ctrl;
  import riscv_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           dmem_periph_req;
  logic           dmem_we_i;
  logic [AW-1:0]  dmem_addr_i;
  logic [DW-1:0]  dmem_wdata_i;
  logic [SW-1:0]  dmem_wstrb_i;
  logic           mem_done_o;
  logic [DW-1:0]  mem_rdata_o;
  logic           mem_err_o;
  logic           bus_req_valid_o;
  logic           bus_req_ready_i;
  logic           bus_req_we_o;
  logic [AW-1:0]  bus_req_addr_o;
  logic [DW-1:0]  bus_req_wdata_o;
  logic [SW-1:0]  bus_req_wstrb_o;
  logic           bus_rsp_valid_i;
  logic [DW-1:0]  bus_rsp_rdata_i;
  logic           bus_rsp_err_i;
  dmem_state_t    dbg_state;

  dmem_bus_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .dmem_periph_req(dmem_periph_req),
    .dmem_we_i(dmem_we_i),
    .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_wstrb_i(dmem_wstrb_i),
    .mem_done_o(mem_done_o),
    .mem_rdata_o(mem_rdata_o),
    .mem_err_o(mem_err_o),
    .bus_req_valid_o(bus_req_valid_o),
    .bus_req_ready_i(bus_req_ready_i),
    .bus_req_we_o(bus_req_we_o),
    .bus_req_addr_o(bus_req_addr_o),
    .bus_req_wdata_o(bus_req_wdata_o),
    .bus_req_wstrb_o(bus_req_wstrb_o),
    .bus_rsp_valid_i(bus_rsp_valid_i),
    .bus_rsp_rdata_i(bus_rsp_rdata_i),
    .bus_rsp_err_i(bus_rsp_err_i),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got sim time %0t, required finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  // ---------------- scoreboard ----------------
  // done entry: {expected done cycle, err, rdata}; bus entry: {we, addr, wdata, wstrb}
  logic [64:0] exp_q[$];
  logic [68:0] bus_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_bus    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  logic [64:0] mon_e;
  always @(negedge clk_i) begin
    #1;
    if (mem_done_o !== 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'(mem_done_o), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e[64:33]));
        check("done_rdata", 64'(mem_rdata_o), 64'(mon_e[31:0]));
        check("done_err", 64'(mem_err_o), 64'(mon_e[32]));
      end
    end
  end

  logic [68:0] mon_b;
  always @(negedge clk_i) begin
    #1;
    if (bus_req_valid_o === 1'b1 && bus_req_ready_i === 1'b1) begin
      n_bus++;
      if (bus_q.size() == 0) check("unexpected_bus_req", 64'd1, 64'd0);
      else begin
        mon_b = bus_q.pop_front();
        check("bus_we", 64'(bus_req_we_o), 64'(mon_b[68]));
        check("bus_addr", 64'(bus_req_addr_o), 64'(mon_b[67:36]));
        check("bus_wdata", 64'(bus_req_wdata_o), 64'(mon_b[35:4]));
        check("bus_wstrb", 64'(bus_req_wstrb_o), 64'(mon_b[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    check({tag, "_done"}, 64'(mem_done_o), 64'd0);
    check({tag, "_err"}, 64'(mem_err_o), 64'd0);
    check({tag, "_rdata"}, 64'(mem_rdata_o), 64'd0);
    check({tag, "_valid"}, 64'(bus_req_valid_o), 64'd0);
    check({tag, "_we"}, 64'(bus_req_we_o), 64'd0);
    check({tag, "_addr"}, 64'(bus_req_addr_o), 64'd0);
    check({tag, "_wdata"}, 64'(bus_req_wdata_o), 64'd0);
    check({tag, "_wstrb"}, 64'(bus_req_wstrb_o), 64'd0);
  endtask

  // Called at a negedge. The bus window (valid first seen to done) is 2 + stall cycles, or
  // TO cycles when the slave never readies.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int rdly, input int rspdly,
                         input logic [31:0] rdata, input logic err, input bit timeout,
                         input bit withdraw, input bit hold_req, input int launch_lat);
    int n;
    int vr;
    int dc;
    logic [3:0] exp_strb;
    exp_strb = we ? wstrb : 4'b0000;
    dmem_periph_req = 1'b1;
    dmem_we_i       = we;
    dmem_addr_i     = addr;
    dmem_wdata_i    = wdata;
    dmem_wstrb_i    = wstrb;
    n = 0;
    while (bus_req_valid_o !== 1'b1 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("launch_latency", 64'(n), 64'(launch_lat));
    if (bus_req_valid_o !== 1'b1) begin
      dmem_periph_req = 1'b0;
      @(negedge clk_i);
      return;
    end
    vr = cyc;
    dc = timeout ? vr + TO : vr + 2 + rdly + rspdly;
    if (!timeout) bus_q.push_back({we, addr, wdata, exp_strb});
    if (!withdraw)
      exp_q.push_back({32'(dc), (timeout ? 1'b1 : err), (timeout ? 32'h0 : rdata)});
    if (timeout) begin
      for (int i = 1; i < TO; i++) begin
        @(negedge clk_i);
        check("to_valid_held", 64'(bus_req_valid_o), 64'd1);
      end
      @(negedge clk_i);
      check("to_valid_dropped", 64'(bus_req_valid_o), 64'd0);
    end else begin
      for (int i = 0; i < rdly; i++) begin
        check("bp_valid", 64'(bus_req_valid_o), 64'd1);
        check("bp_addr", 64'(bus_req_addr_o), 64'(addr));
        check("bp_wdata", 64'(bus_req_wdata_o), 64'(wdata));
        check("bp_wstrb", 64'(bus_req_wstrb_o), 64'(exp_strb));
        @(negedge clk_i);
      end
      bus_req_ready_i = 1'b1;
      if (withdraw) dmem_periph_req = 1'b0;
      @(negedge clk_i);
      bus_req_ready_i = 1'b0;
      for (int i = 0; i < rspdly; i++) @(negedge clk_i);
      bus_rsp_valid_i = 1'b1;
      bus_rsp_rdata_i = rdata;
      bus_rsp_err_i   = err;
      @(negedge clk_i);
      bus_rsp_valid_i = 1'b0;
      bus_rsp_err_i   = 1'b0;
      bus_rsp_rdata_i = $urandom;
    end
    if (withdraw) begin
      check("withdrawn_no_done", 64'(mem_done_o), 64'd0);
      @(negedge clk_i);
    end else if (!hold_req) begin
      dmem_periph_req = 1'b0;
      @(negedge clk_i);
    end
  endtask

  // ---------------- stimulus ----------------
  int  nb;
  bit  prev_hold;
  bit  hold;
  logic r_we;
  logic [31:0] r_addr;

  initial begin
    rst_i           = 1'b1;
    dmem_periph_req = 1'b0;
    dmem_we_i       = 1'b0;
    dmem_addr_i     = '0;
    dmem_wdata_i    = '0;
    dmem_wstrb_i    = '0;
    bus_req_ready_i = 1'b0;
    bus_rsp_valid_i = 1'b0;
    bus_rsp_rdata_i = '0;
    bus_rsp_err_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // load, zero wait
    run_txn(1'b0, 32'h0000_1000, 32'h5555_AAAA, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 1);
    // store with 5 cycles of backpressure
    run_txn(1'b1, 32'h0000_2004, 32'h0000_AB00, 4'b0010, 5, 0, 32'h0, 1'b0, 0, 0, 0, 1);
    // slave error, then err must not linger
    run_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 1, 32'h1234_5678, 1'b1, 0, 0, 0, 1);
    check("err_one_cycle", 64'(mem_err_o), 64'd0);
    // watchdog: slave never readies
    run_txn(1'b0, 32'h0000_4000, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1, 0, 0, 1);
    check("to_back_idle", 64'(dbg_state), 64'(IDLE));

    // stray response in IDLE, then back-to-back with request held across DONE
    bus_rsp_valid_i = 1'b1;
    bus_rsp_err_i   = 1'b1;
    bus_rsp_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    bus_rsp_valid_i = 1'b0;
    bus_rsp_err_i   = 1'b0;
    check("stray_still_idle", 64'(dbg_state), 64'(IDLE));
    nb = n_bus;
    run_txn(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 0, 32'hCAFE_0001, 1'b0, 0, 0, 1, 1);
    run_txn(1'b1, 32'h0000_5004, 32'h1111_2222, 4'b1100, 1, 0, 32'h0, 1'b0, 0, 0, 0, 2);
    check("b2b_bus_count", 64'(n_bus - nb), 64'd2);

    // request withdrawn in REQ: bus completes, no done pulse
    run_txn(1'b0, 32'h0000_6000, 32'h0, 4'h0, 1, 1, 32'h7777_7777, 1'b0, 0, 1, 0, 1);
    check("withdraw_idle", 64'(dbg_state), 64'(IDLE));

    // reset during WAIT
    dmem_periph_req = 1'b1;
    dmem_we_i       = 1'b0;
    dmem_addr_i     = 32'h0000_7000;
    dmem_wdata_i    = 32'h0;
    dmem_wstrb_i    = 4'h0;
    bus_q.push_back({1'b0, 32'h0000_7000, 32'h0, 4'h0});
    @(negedge clk_i);
    check("rstw_valid", 64'(bus_req_valid_o), 64'd1);
    bus_req_ready_i = 1'b1;
    @(negedge clk_i);
    bus_req_ready_i = 1'b0;
    check("rstw_in_wait", 64'(dbg_state), 64'(WAIT));
    rst_i           = 1'b1;
    dmem_periph_req = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle_outputs("rst_wait");
    run_txn(1'b0, 32'h0000_7004, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 0, 0, 0, 1);

    // randomized traffic
    prev_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = $urandom & 32'hFFFF_FFFC;
      hold   = (i == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      run_txn(r_we, r_addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom, ($urandom_range(0, 7) == 0), 0, 0, hold,
              prev_hold ? 2 : 1);
      prev_hold = hold;
    end

    repeat (3) @(negedge clk_i);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
